// File: rtl/playfield_store.sv
// playfield_store: 10x28 locked-cell store with row collapse, BCD scoring and pixel/collision lookup.
// Optional feature macro PLAYFIELD_CLEAR_FLASH_EN shows full rows white for FLASH_CYCLES before they collapse.
module playfield_store
`ifdef PLAYFIELD_CLEAR_FLASH_EN
  #(parameter int FLASH_CYCLES = 8)
`endif
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        clear_board,
  input  logic        lock_valid,
  output logic        lock_ready,
  input  logic [15:0] lock_col,
  input  logic [19:0] lock_row,
  input  logic [2:0]  lock_color,
  input  logic [3:0]  query_col,
  input  logic [4:0]  query_row,
  output logic        query_occupied,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic        locked_block,
  output logic [2:0]  locked_block_color_code,
  output logic [11:0] score,
  output logic        game_over,
  output logic        busy
);
  localparam logic [2:0] IDLE = 3'd0, WRITE = 3'd1, SCAN = 3'd2, SHIFT = 3'd3, SCORE = 3'd4;
`ifdef PLAYFIELD_CLEAR_FLASH_EN
  localparam logic [2:0] FLASH = 3'd5;
  localparam logic [2:0] ON_FULL = FLASH;
  localparam int FW = FLASH_CYCLES > 1 ? $clog2(FLASH_CYCLES) : 1;
  logic [FW-1:0] fcnt_q;
`else
  localparam logic [2:0] ON_FULL = SHIFT;
`endif
  logic [2:0]  cell_q [28][10];
  logic [2:0]  state_q, state_d;
  logic [4:0]  ptr_q;
  logic [2:0]  lines_q;
  logic [11:0] score_q, score_d;
  logic        over_q;
  logic [15:0] col_q;
  logic [19:0] row_q;
  logic [2:0]  color_q;
  logic        row_full, in_area, flash_hit;
  logic [4:0]  pix_row;
  logic [3:0]  pix_col;
  logic [2:0]  pix_code;
  logic [3:0]  pts;
  logic [4:0]  s0, s1, s2;
  assign pix_row = 5'((DrawY - 10'd16) >> 4);
  assign pix_col = 4'((DrawX - 10'd240) >> 4);
  assign in_area = DrawX >= 10'd240 && DrawX < 10'd400 && DrawY >= 10'd16 && DrawY < 10'd464;
  assign pix_code = cell_q[pix_row][pix_col];
`ifdef PLAYFIELD_CLEAR_FLASH_EN
  assign flash_hit = state_q == FLASH && pix_row == ptr_q;
`else
  assign flash_hit = 1'b0;
`endif
  assign locked_block = in_area && (flash_hit || pix_code != 3'd0);
  assign locked_block_color_code = in_area && !flash_hit ? pix_code : 3'd0;
  assign query_occupied = query_col >= 4'd10 || query_row >= 5'd28 || cell_q[query_row][query_col] != 3'd0;
  assign lock_ready = state_q == IDLE && !over_q;
  assign busy = state_q != IDLE;
  assign score = score_q;
  assign game_over = over_q;
  // Row under the scan pointer is full when every column holds a non-zero code
  always_comb begin
    row_full = 1'b1;
    for (int c = 0; c < 10; c++) row_full = row_full && cell_q[ptr_q][c] != 3'd0;
  end
  // Saturating three-digit BCD add of the points earned by this lock
  always_comb begin
    pts = lines_q == 3'd1 ? 4'd1 : lines_q == 3'd2 ? 4'd3 : lines_q == 3'd3 ? 4'd5 : lines_q == 3'd4 ? 4'd8 : 4'd0;
    s0 = {1'b0, score_q[3:0]} + {1'b0, pts};
    s1 = {1'b0, score_q[7:4]} + {4'd0, s0 > 5'd9};
    s2 = {1'b0, score_q[11:8]} + {4'd0, s1 > 5'd9};
    score_d = s2 > 5'd9 ? 12'h999 : {s2[3:0], s1 > 5'd9 ? s1[3:0] - 4'd10 : s1[3:0], s0 > 5'd9 ? s0[3:0] - 4'd10 : s0[3:0]};
  end
  // Next state: accept a lock, sweep rows bottom-up, collapse full rows, then score
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = lock_valid && lock_ready ? WRITE : IDLE;
      WRITE:   state_d = SCAN;
      SCAN:    state_d = row_full ? ON_FULL : ptr_q == 5'd0 ? SCORE : SCAN;
`ifdef PLAYFIELD_CLEAR_FLASH_EN
      FLASH:   state_d = fcnt_q == FW'(FLASH_CYCLES - 1) ? SHIFT : FLASH;
`endif
      SHIFT:   state_d = SCAN;
      default: state_d = IDLE;
    endcase
  end
  // Cell array, FSM, scan pointer and score; clear_board wipes the game on the clock
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int r = 0; r < 28; r++) for (int c = 0; c < 10; c++) cell_q[r][c] <= '0;
      state_q <= IDLE;
      ptr_q <= '0;
      lines_q <= '0;
      score_q <= '0;
      over_q <= 1'b0;
      col_q <= '0;
      row_q <= '0;
      color_q <= '0;
    end else if (clear_board) begin
      for (int r = 0; r < 28; r++) for (int c = 0; c < 10; c++) cell_q[r][c] <= '0;
      state_q <= IDLE;
      ptr_q <= '0;
      lines_q <= '0;
      score_q <= '0;
      over_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        col_q <= lock_col;
        row_q <= lock_row;
        color_q <= lock_color;
      end
      if (state_q == WRITE) begin
        for (int i = 0; i < 4; i++)
          if (col_q[4*i+:4] < 4'd10 && row_q[5*i+:5] < 5'd28) begin
            cell_q[row_q[5*i+:5]][col_q[4*i+:4]] <= color_q;
            if (row_q[5*i+:5] == 5'd0) over_q <= 1'b1;
          end
        lines_q <= '0;
        ptr_q <= 5'd27;
      end
      if (state_q == SCAN && !row_full && ptr_q != 5'd0) ptr_q <= ptr_q - 5'd1;
      if (state_q == SHIFT) begin
        for (int r = 1; r < 28; r++) if (5'(r) <= ptr_q) cell_q[r] <= cell_q[r-1];
        for (int c = 0; c < 10; c++) cell_q[0][c] <= '0;
        lines_q <= lines_q + 3'd1;
      end
      if (state_q == SCORE) score_q <= score_d;
    end
  end
`ifdef PLAYFIELD_CLEAR_FLASH_EN
  // Flash dwell counter, restarted on every entry into FLASH
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) fcnt_q <= '0;
    else fcnt_q <= state_q == FLASH && !clear_board ? fcnt_q + 1'b1 : '0;
  end
`endif
endmodule

// File: tb/tb_playfield_store.sv
// tb_playfield_store: scoreboard bench for playfield_store with a board/score reference model
module tb_playfield_store;
  logic        Clk = 1'b0, Reset = 1'b1, clear_board = 1'b0, lock_valid = 1'b0;
  logic        lock_ready, query_occupied, locked_block, game_over, busy;
  logic [15:0] lock_col = '1;
  logic [19:0] lock_row = '1;
  logic [2:0]  lock_color = '0;
  logic [3:0]  query_col = '0;
  logic [4:0]  query_row = '0;
  logic [9:0]  DrawX = '0, DrawY = '0;
  logic [2:0]  locked_block_color_code;
  logic [11:0] score;
  int vec = 0, err = 0;
  int m [28][10];
  int m_score = 0;
  bit m_over = 1'b0;
  typedef struct {int cycles; logic [11:0] score; logic over;} exp_t;
  exp_t sb [$];
`ifdef PLAYFIELD_CLEAR_FLASH_EN
  localparam int FL = 8;
`else
  localparam int FL = 0;
`endif

  playfield_store dut (
    .Clk(Clk), .Reset(Reset), .clear_board(clear_board), .lock_valid(lock_valid), .lock_ready(lock_ready),
    .lock_col(lock_col), .lock_row(lock_row), .lock_color(lock_color), .query_col(query_col),
    .query_row(query_row), .query_occupied(query_occupied), .DrawX(DrawX), .DrawY(DrawY),
    .locked_block(locked_block), .locked_block_color_code(locked_block_color_code), .score(score),
    .game_over(game_over), .busy(busy)
  );

  always #5 Clk = ~Clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [15:0] pc(input int a, input int b, input int c, input int d);
    return {4'(d), 4'(c), 4'(b), 4'(a)};
  endfunction

  function automatic logic [19:0] pr(input int a, input int b, input int c, input int d);
    return {5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 28; r++) for (int c = 0; c < 10; c++) m[r][c] = 0;
    m_score = 0;
    m_over = 1'b0;
  endtask

  task automatic model_lock(input logic [15:0] c, input logic [19:0] r, input logic [2:0] k);
    int pts [5] = '{0, 1, 3, 5, 8};
    int p, lines;
    bit full;
    exp_t e;
    for (int i = 0; i < 4; i++)
      if (c[4*i+:4] < 10 && r[5*i+:5] < 28) begin
        m[r[5*i+:5]][c[4*i+:4]] = int'(k);
        if (r[5*i+:5] == 0) m_over = 1'b1;
      end
    p = 27;
    lines = 0;
    forever begin
      full = 1'b1;
      for (int x = 0; x < 10; x++) if (m[p][x] == 0) full = 1'b0;
      if (full) begin
        for (int y = p; y > 0; y--) m[y] = m[y-1];
        for (int x = 0; x < 10; x++) m[0][x] = 0;
        lines++;
      end else if (p == 0) break;
      else p--;
    end
    m_score = m_score + pts[lines] > 999 ? 999 : m_score + pts[lines];
    e.cycles = 31 + lines * (2 + FL);
    e.score = to_bcd(m_score);
    e.over = m_over;
    sb.push_back(e);
  endtask

  task automatic verify_board();
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 10; c++) begin
        DrawX = 10'(240 + 16 * c + int'($urandom_range(15)));
        DrawY = 10'(16 + 16 * r + int'($urandom_range(15)));
        query_col = 4'(c);
        query_row = 5'(r);
        #1;
        vec++;
        if (locked_block !== (m[r][c] != 0) || locked_block_color_code !== 3'(m[r][c]) || query_occupied !== (m[r][c] != 0)) begin
          err++;
          $display("FAIL cell r%0d c%0d: block=%b code=%0d query=%b, required code %0d", r, c, locked_block, locked_block_color_code, query_occupied, m[r][c]);
        end
      end
  endtask

  task automatic do_lock(input logic [15:0] c, input logic [19:0] r, input logic [2:0] k);
    int n;
    logic go;
    exp_t e;
    model_lock(c, r, k);
    @(negedge Clk);
    lock_col = c;
    lock_row = r;
    lock_color = k;
    lock_valid = 1'b1;
    n = 0;
    while (!lock_ready && n < 100) begin @(negedge Clk); n++; end
    if (!lock_ready) begin
      vec++;
      err++;
      $display("FAIL lock_accept: lock_ready=%b after %0d cycles, required 1", lock_ready, n);
      lock_valid = 1'b0;
      void'(sb.pop_front());
      return;
    end
    @(posedge Clk);
    #1 lock_valid = 1'b0;
    lock_col = '1;
    lock_row = '1;
    n = 0;
    go = 1'bx;
    do begin
      @(negedge Clk);
      n++;
      if (n == 2) go = game_over;
    end while (busy && n < 200);
    e = sb.pop_front();
    vec++;
    if (n !== e.cycles) begin err++; $display("FAIL lock_latency: %0d cycles, required %0d", n, e.cycles); end
    vec++;
    if (score !== e.score) begin err++; $display("FAIL score: %h, required %h", score, e.score); end
    vec++;
    if (go !== e.over) begin err++; $display("FAIL game_over_after_write: %b, required %b", go, e.over); end
    vec++;
    if (game_over !== e.over) begin err++; $display("FAIL game_over: %b, required %b", game_over, e.over); end
    vec++;
    if (lock_ready !== !e.over) begin err++; $display("FAIL lock_ready_after: %b, required %b", lock_ready, !e.over); end
    verify_board();
  endtask

  task automatic test_clear_board();
    @(negedge Clk);
    clear_board = 1'b1;
    lock_valid = 1'b1;
    lock_col = pc(0, 1, 2, 3);
    lock_row = pr(27, 27, 27, 27);
    lock_color = 3'd1;
    @(negedge Clk);
    clear_board = 1'b0;
    lock_valid = 1'b0;
    model_clear();
    vec++;
    if (busy !== 1'b0) begin err++; $display("FAIL clear_priority: busy=%b, required 0", busy); end
    vec++;
    if (score !== 12'h000 || game_over !== 1'b0 || lock_ready !== 1'b1) begin
      err++;
      $display("FAIL clear_state: score=%h over=%b ready=%b, required 000 0 1", score, game_over, lock_ready);
    end
    verify_board();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    vec++;
    if (busy !== 1'b0 || lock_ready !== 1'b1 || score !== 12'h000 || game_over !== 1'b0) begin
      err++;
      $display("FAIL reset_state: busy=%b ready=%b score=%h over=%b, required 0 1 000 0", busy, lock_ready, score, game_over);
    end
    Reset = 1'b0;
    model_clear();
    verify_board();
  endtask

  task automatic test_query();
    logic [3:0] qc [4] = '{4'd10, 4'd3, 4'd3, 4'd15};
    logic [4:0] qr [4] = '{5'd5, 5'd28, 5'd5, 5'd31};
    logic       qe [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      query_col = qc[i];
      query_row = qr[i];
      #1;
      vec++;
      if (query_occupied !== qe[i]) begin
        err++;
        $display("FAIL query c%0d r%0d: %b, required %b", qc[i], qr[i], query_occupied, qe[i]);
      end
    end
  endtask

  task automatic test_o_piece();
    int px [4] = '{304, 239, 400, 304};
    int py [4] = '{448, 448, 448, 15};
    do_lock(pc(4, 5, 4, 5), pr(26, 26, 27, 27), 3'd4);
    for (int i = 0; i < 4; i++) begin
      DrawX = 10'(px[i]);
      DrawY = 10'(py[i]);
      #1;
      vec++;
      if (locked_block !== (i == 0) || locked_block_color_code !== (i == 0 ? 3'd4 : 3'd0)) begin
        err++;
        $display("FAIL pixel x%0d y%0d: block=%b code=%0d, required %b %0d", px[i], py[i], locked_block, locked_block_color_code, i == 0, i == 0 ? 4 : 0);
      end
    end
  endtask

  task automatic test_single_clear();
    do_lock(pc(0, 1, 2, 3), pr(27, 27, 27, 27), 3'd1);
    do_lock(pc(9, 15, 15, 15), pr(27, 0, 0, 0), 3'd2);
    do_lock(pc(8, 8, 8, 8), pr(24, 25, 26, 27), 3'd3);
    do_lock(pc(6, 6, 6, 7), pr(25, 26, 27, 27), 3'd5);
  endtask

  task automatic build_rows(input int lo);
    for (int r = lo; r < 28; r++) begin
      do_lock(pc(0, 1, 2, 3), pr(r, r, r, r), 3'd1);
      do_lock(pc(4, 5, 6, 7), pr(r, r, r, r), 3'd2);
      do_lock(pc(8, 15, 15, 15), pr(r, 31, 31, 31), 3'd3);
    end
  endtask

  task automatic test_tetris();
    test_clear_board();
    build_rows(24);
    do_lock(pc(9, 9, 9, 9), pr(24, 25, 26, 27), 3'd6);
  endtask

  task automatic test_saturate();
    int pre [2] = '{97, 997};
    for (int i = 0; i < 2; i++) begin
      test_clear_board();
      @(negedge Clk);
      force dut.score_q = to_bcd(pre[i]);
      @(negedge Clk);
      release dut.score_q;
      m_score = pre[i];
      build_rows(26);
      do_lock(pc(9, 9, 15, 15), pr(26, 27, 31, 31), 3'd7);
    end
  endtask

  task automatic test_reset_mid();
    do_lock(pc(0, 1, 2, 3), pr(27, 27, 27, 27), 3'd6);
    @(negedge Clk);
    lock_col = pc(0, 1, 2, 3);
    lock_row = pr(26, 26, 26, 26);
    lock_color = 3'd2;
    lock_valid = 1'b1;
    @(posedge Clk);
    #1 lock_valid = 1'b0;
    repeat (10) @(negedge Clk);
    vec++;
    if (busy !== 1'b1) begin err++; $display("FAIL mid_scan_busy: %b, required 1", busy); end
    DrawX = 10'd244;
    DrawY = 10'd452;
    query_col = 4'd0;
    query_row = 5'd27;
    #2 Reset = 1'b1;
    #1;
    vec++;
    if (busy !== 1'b0 || lock_ready !== 1'b1 || score !== 12'h000 || game_over !== 1'b0) begin
      err++;
      $display("FAIL async_reset_state: busy=%b ready=%b score=%h over=%b, required 0 1 000 0", busy, lock_ready, score, game_over);
    end
    vec++;
    if (locked_block !== 1'b0 || locked_block_color_code !== 3'd0 || query_occupied !== 1'b0) begin
      err++;
      $display("FAIL async_reset_cells: block=%b code=%0d query=%b, required 0 0 0", locked_block, locked_block_color_code, query_occupied);
    end
    @(negedge Clk);
    Reset = 1'b0;
    model_clear();
    verify_board();
  endtask

  task automatic test_game_over();
    do_lock(pc(0, 15, 15, 15), pr(0, 31, 31, 31), 3'd7);
    @(negedge Clk);
    lock_col = pc(5, 5, 5, 5);
    lock_row = pr(27, 27, 27, 27);
    lock_color = 3'd1;
    lock_valid = 1'b1;
    repeat (5) @(negedge Clk);
    vec++;
    if (busy !== 1'b0 || lock_ready !== 1'b0) begin
      err++;
      $display("FAIL locked_out: busy=%b ready=%b, required 0 0", busy, lock_ready);
    end
    lock_valid = 1'b0;
    test_clear_board();
  endtask

  initial begin
    test_reset();
    test_query();
    test_o_piece();
    test_single_clear();
    test_tetris();
    test_saturate();
    test_reset_mid();
    test_game_over();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
